branch_unit: RTL and testbench
==============================

# branch_unit

Resolves jumps and conditional branches for the RV32I core and drives the redirect inputs of the program counter: jump/branch target, jump enable and branch enable. It accepts one decoded control-flow instruction per cycle and registers the redirect decision. After each redirect it runs a flush window that kills wrong-path instructions already in flight. It also produces the link value (pc + 4) for JAL/JALR.

## Interface
- FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect pulse (≥1)
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- in_valid  input  1  decoded instruction present this cycle
- is_jal  input  1  instruction is JAL
- is_jalr  input  1  instruction is JALR
- is_branch  input  1  instruction is B-type
- funct3  input  3  branch condition select
- pc  input  32  address of the instruction
- rs1  input  32  source operand 1
- rs2  input  32  source operand 2
- imm  input  32  sign-extended immediate
- jmp  output  32  registered redirect target
- jpe  output  1  one-cycle pulse: jump (JAL/JALR) redirect
- brch_e  output  1  one-cycle pulse: taken-branch redirect
- link  output  32  registered pc + 4 of the accepted JAL/JALR
- link_we  output  1  one-cycle pulse: link valid for rd writeback
- flush  output  1  high while wrong-path instructions must be killed
- misalign  output  1  one-cycle pulse: target not 4-byte aligned (see Configuration)

## Operation
- States: IDLE, FLUSH.
- Accept condition: in_valid && state == IDLE. Inputs are ignored in FLUSH (wrong path).
- Type priority when several flags are set: is_jal > is_jalr > is_branch. If no flag is set, the instruction is a no-op for this block.
- Targets, all mod 2^32:
  - JAL and branch: pc + imm.
  - JALR: (rs1 + imm) & 0xFFFF_FFFE.
- Branch conditions:
  - funct3 000: BEQ (rs1 == rs2); 001: BNE.
  - 100: BLT, signed; 101: BGE, signed.
  - 110: BLTU, unsigned; 111: BGEU, unsigned.
  - 010 and 011: never taken.
- Taken (JAL, JALR, or branch condition true), with no misalignment:
  - Next cycle: jmp = target, and jpe (jump) or brch_e (branch) pulses high.
  - For JAL/JALR, link = pc + 4 and link_we pulses in the same cycle.
  - Transition to FLUSH with counter = FLUSH_CYCLES.
- Not-taken branch: no outputs pulse; the block stays in IDLE.
- FLUSH:
  - flush = 1; the counter decrements each cycle.
  - Return to IDLE when the counter reaches 1, so flush is high for exactly FLUSH_CYCLES cycles, starting in the cycle jpe/brch_e is high.
- jmp and link hold their last value when not pulsing.
- Reset, including mid-FLUSH:
  - state = IDLE, counter = 0, jmp = 0, link = 0.
  - jpe, brch_e, link_we, flush, misalign = 0.
  - A pending redirect is discarded.

## Timing
- Decision latency: 1 cycle from the accepting edge to jpe/brch_e/link_we.
- jpe and brch_e are never high together. Each is high for exactly one cycle per accepted taken instruction.
- Back-to-back taken instructions: the second one arrives during FLUSH and is dropped. At most one redirect per FLUSH_CYCLES + 1 cycles.
- An instruction presented in the cycle where FLUSH returns to IDLE is not accepted. Acceptance resumes on the following cycle.
- The counter width is sufficient to hold FLUSH_CYCLES. There is no wrap-around.

## Configuration
- BRANCH_MISALIGN_EN defined:
  - A taken target with target[1] == 1 suppresses jpe, brch_e and link_we.
  - misalign pulses for one cycle at the normal redirect time, and FLUSH is still entered.
- Macro undefined:
  - misalign is tied to 0.
  - Misaligned targets redirect normally.

## Test plan
- Reset while in FLUSH after a JAL: all outputs read 0 immediately. The next in_valid BEQ pc=0x10, rs1=rs2=5, imm=8 is accepted, and jmp=0x18 with brch_e pulsing one cycle later.
- JAL pc=0x100, imm=0x20: after 1 cycle, jpe=1, jmp=0x120, link=0x104, link_we=1. flush is high for 2 cycles, and no brch_e.
- JALR rs1=0x2001, imm=0x4: jmp=0x2004 (bit 0 cleared), jpe pulse.
- BLT rs1=0xFFFF_FFFF, rs2=1 is taken. BLTU with the same operands is not taken: no pulse, flush stays 0.
- Taken BNE immediately followed by JAL on the next two cycles: only the brch_e redirect occurs; the JAL is dropped during flush.
- With BRANCH_MISALIGN_EN, JAL pc=0x0, imm=0x6: misalign pulses, jpe=0, link_we=0, flush is high for 2 cycles. Without the macro: jpe=1, jmp=0x6.

Source files
------------

// File: rtl/branch_unit.sv
// Control-flow resolver for RV32I: computes jump/branch targets, pulses the PC redirect and
// holds a flush window afterwards. Optional macro BRANCH_MISALIGN_EN traps targets with bit 1 set.
module branch_unit #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        is_branch,
  input  logic [2:0]  funct3,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  output logic [31:0] jmp,
  output logic        jpe,
  output logic        brch_e,
  output logic [31:0] link,
  output logic        link_we,
  output logic        flush,
  output logic        misalign
);

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [31:0] target_p0;
  logic        is_jump_p0;
  logic        taken_p0;
  logic        accept_p0;
  logic        misal_p0;
  logic        redirect_p0;

  function automatic logic cond_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Stage p0: decode, target and taken decision from the presented instruction
  always_comb begin
    if (is_jal)       target_p0 = pc + imm;
    else if (is_jalr) target_p0 = (rs1 + imm) & 32'hFFFF_FFFE;
    else              target_p0 = pc + imm;
  end

  assign is_jump_p0  = is_jal | is_jalr;
  assign taken_p0    = is_jump_p0 | (is_branch & cond_taken(funct3, rs1, rs2));
  assign accept_p0   = in_valid & (state == IDLE) & taken_p0;
`ifdef BRANCH_MISALIGN_EN
  assign misal_p0    = target_p0[1];
`else
  assign misal_p0    = 1'b0;
`endif
  assign redirect_p0 = accept_p0 & ~misal_p0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept_p0) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stage p1: registered redirect, link and pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jmp     <= '0;
      link    <= '0;
      jpe     <= 1'b0;
      brch_e  <= 1'b0;
      link_we <= 1'b0;
    end else begin
      jpe     <= redirect_p0 & is_jump_p0;
      brch_e  <= redirect_p0 & ~is_jump_p0;
      link_we <= redirect_p0 & is_jump_p0;
      if (redirect_p0)
        jmp <= target_p0;
      if (redirect_p0 && is_jump_p0)
        link <= pc + 32'd4;
    end
  end

`ifdef BRANCH_MISALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign <= 1'b0;
    else        misalign <= accept_p0 & misal_p0;
  end
`else
  assign misalign = 1'b0;
`endif

  assign flush = (state == FLUSH);

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized traffic against a
// cycle-level reference model of redirect/flush behaviour.
module tb_branch_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, is_jal, is_jalr, is_branch;
  logic [2:0]  funct3;
  logic [31:0] pc, rs1, rs2, imm;
  logic [31:0] jmp, link;
  logic        jpe, brch_e, link_we, flush, misalign;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          flush_left = 0;
  logic [31:0] e_jmp = '0, e_link = '0;
  logic        e_jpe = 0, e_brch = 0, e_lwe = 0, e_mis = 0;

`ifdef BRANCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  branch_unit #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .is_jal(is_jal), .is_jalr(is_jalr),
    .is_branch(is_branch), .funct3(funct3), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .jmp(jmp), .jpe(jpe), .brch_e(brch_e), .link(link), .link_we(link_we), .flush(flush),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  // Present one instruction for a cycle, clock it, update the model, settle 1 ns after the edge.
  task automatic step(input logic v, input logic jal, input logic jalr, input logic br,
                      input logic [2:0] f3, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im);
    logic [31:0] tgt;
    bit          tk;
    in_valid = v; is_jal = jal; is_jalr = jalr; is_branch = br;
    funct3 = f3; pc = p; rs1 = a; rs2 = b; imm = im;
    @(posedge clk);
    e_jpe = 0; e_brch = 0; e_lwe = 0; e_mis = 0;
    if (flush_left > 0) begin
      flush_left--;
    end else if (v) begin
      if (jal)       begin tgt = p + im;                tk = 1; end
      else if (jalr) begin tgt = (a + im) & ~32'd1;     tk = 1; end
      else if (br)   begin tgt = p + im;                tk = model_taken(f3, a, b); end
      else           begin tgt = '0;                    tk = 0; end
      if (tk) begin
        if (MIS_EN && tgt[1]) e_mis = 1;
        else begin
          e_jmp = tgt;
          if (jal || jalr) begin e_jpe = 1; e_lwe = 1; e_link = p + 4; end
          else e_brch = 1;
        end
        flush_left = FC;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic model_reset();
    flush_left = 0; e_jmp = '0; e_link = '0;
    e_jpe = 0; e_brch = 0; e_lwe = 0; e_mis = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 0; is_jal = 0; is_jalr = 0; is_branch = 0;
    funct3 = '0; pc = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({jmp, link, jpe, brch_e, link_we, flush, misalign} !== '0) begin
      errors++;
      $display("FAIL reset_state got jmp=%h link=%h pulses=%b required all 0", jmp, link,
               {jpe, brch_e, link_we, flush, misalign});
    end
    reset = 1'b1;
  endtask

  task automatic test_jal();
    step(1, 1, 0, 0, 3'd0, 32'h100, 32'd0, 32'd0, 32'h20);
    checks++;
    if ({jpe, brch_e, link_we, flush} !== 4'b1011 || jmp !== 32'h120 || link !== 32'h104) begin
      errors++;
      $display("FAIL jal_redirect got jpe=%b brch_e=%b link_we=%b flush=%b jmp=%h link=%h required 1 0 1 1 00000120 00000104",
               jpe, brch_e, link_we, flush, jmp, link);
    end
    idle();
    checks++;
    if ({jpe, brch_e, link_we, flush} !== 4'b0001) begin
      errors++;
      $display("FAIL jal_flush2 got jpe/brch_e/link_we/flush=%b required 0001",
               {jpe, brch_e, link_we, flush});
    end
    idle();
    checks++;
    if (flush !== 1'b0 || jmp !== 32'h120 || link !== 32'h104) begin
      errors++;
      $display("FAIL jal_flush_end got flush=%b jmp=%h link=%h required 0 00000120 00000104",
               flush, jmp, link);
    end
  endtask

  task automatic test_jalr();
    step(1, 0, 1, 0, 3'd0, 32'h40, 32'h2001, 32'd0, 32'h4);
    checks++;
    if (jpe !== 1'b1 || jmp !== 32'h2004 || link !== 32'h44) begin
      errors++;
      $display("FAIL jalr_target got jpe=%b jmp=%h link=%h required 1 00002004 00000044", jpe, jmp, link);
    end
    idle(); idle();
  endtask

  task automatic test_signed_unsigned();
    step(1, 0, 0, 1, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10);
    checks++;
    if (brch_e !== 1'b1 || jpe !== 1'b0 || link_we !== 1'b0 || jmp !== 32'h210) begin
      errors++;
      $display("FAIL blt_taken got brch_e=%b jpe=%b link_we=%b jmp=%h required 1 0 0 00000210",
               brch_e, jpe, link_we, jmp);
    end
    idle(); idle();
    step(1, 0, 0, 1, 3'd6, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10);
    checks++;
    if ({jpe, brch_e, link_we, flush} !== 4'b0000 || jmp !== 32'h210) begin
      errors++;
      $display("FAIL bltu_not_taken got pulses/flush=%b jmp=%h required 0000 00000210",
               {jpe, brch_e, link_we, flush}, jmp);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 1, 3'd1, 32'h400, 32'd1, 32'd2, 32'h8);
    checks++;
    if (brch_e !== 1'b1 || jmp !== 32'h408) begin
      errors++;
      $display("FAIL b2b_bne got brch_e=%b jmp=%h required 1 00000408", brch_e, jmp);
    end
    step(1, 1, 0, 0, 3'd0, 32'h500, 32'd0, 32'd0, 32'h40);
    checks++;
    if ({jpe, brch_e, link_we, flush} !== 4'b0001 || jmp !== 32'h408) begin
      errors++;
      $display("FAIL b2b_drop1 got pulses/flush=%b jmp=%h required 0001 00000408",
               {jpe, brch_e, link_we, flush}, jmp);
    end
    step(1, 1, 0, 0, 3'd0, 32'h500, 32'd0, 32'd0, 32'h40);
    checks++;
    if ({jpe, brch_e, link_we, flush} !== 4'b0000 || jmp !== 32'h408) begin
      errors++;
      $display("FAIL b2b_drop2 got pulses/flush=%b jmp=%h required 0000 00000408",
               {jpe, brch_e, link_we, flush}, jmp);
    end
    step(1, 1, 0, 0, 3'd0, 32'h500, 32'd0, 32'd0, 32'h40);
    checks++;
    if (jpe !== 1'b1 || jmp !== 32'h540 || link !== 32'h504) begin
      errors++;
      $display("FAIL b2b_resume got jpe=%b jmp=%h link=%h required 1 00000540 00000504", jpe, jmp, link);
    end
    idle(); idle();
  endtask

  task automatic test_misalign();
    step(1, 1, 0, 0, 3'd0, 32'h0, 32'd0, 32'd0, 32'h6);
    checks++;
`ifdef BRANCH_MISALIGN_EN
    if ({misalign, jpe, link_we, flush} !== 4'b1001 || jmp !== 32'h540) begin
      errors++;
      $display("FAIL misalign_trap got mis/jpe/link_we/flush=%b jmp=%h required 1001 00000540",
               {misalign, jpe, link_we, flush}, jmp);
    end
`else
    if ({misalign, jpe, link_we, flush} !== 4'b0111 || jmp !== 32'h6) begin
      errors++;
      $display("FAIL misalign_plain got mis/jpe/link_we/flush=%b jmp=%h required 0111 00000006",
               {misalign, jpe, link_we, flush}, jmp);
    end
`endif
    idle();
    checks++;
    if (flush !== 1'b1 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL misalign_flush2 got flush=%b misalign=%b required 1 0", flush, misalign);
    end
    idle();
  endtask

  task automatic test_reset_mid_flush();
    step(1, 1, 0, 0, 3'd0, 32'h800, 32'd0, 32'd0, 32'h100);
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({jmp, link, jpe, brch_e, link_we, flush, misalign} !== '0) begin
      errors++;
      $display("FAIL reset_mid_flush got jmp=%h link=%h pulses=%b required all 0", jmp, link,
               {jpe, brch_e, link_we, flush, misalign});
    end
    reset = 1'b1;
    #1;
    step(1, 0, 0, 1, 3'd0, 32'h10, 32'd5, 32'd5, 32'h8);
    checks++;
    if (brch_e !== 1'b1 || jmp !== 32'h18 || flush !== 1'b1) begin
      errors++;
      $display("FAIL beq_after_reset got brch_e=%b jmp=%h flush=%b required 1 00000018 1", brch_e, jmp, flush);
    end
    idle(); idle();
  endtask

  task automatic test_random();
    logic [31:0] a, b, p, im;
    logic        v, jal, jalr, br;
    logic [2:0]  f3;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 9) < 7);
      jal  = ($urandom_range(0, 5) == 0);
      jalr = ($urandom_range(0, 4) == 0);
      br   = ($urandom_range(0, 2) != 0);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      p    = $urandom & 32'hFFFF_FFFC;
      im   = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      step(v, jal, jalr, br, f3, p, a, b, im);
      checks++;
      if ({jmp, jpe, brch_e, link, link_we, flush, misalign} !==
          {e_jmp, e_jpe, e_brch, e_link, e_lwe, (flush_left > 0), e_mis}) begin
        errors++;
        $display("FAIL random[%0d] got jmp=%h jpe=%b brch_e=%b link=%h link_we=%b flush=%b mis=%b required jmp=%h jpe=%b brch_e=%b link=%h link_we=%b flush=%b mis=%b",
                 i, jmp, jpe, brch_e, link, link_we, flush, misalign,
                 e_jmp, e_jpe, e_brch, e_link, e_lwe, (flush_left > 0), e_mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jalr();
    test_signed_unsigned();
    test_back_to_back();
    test_misalign();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
